imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning output immediate width; legal values are 32 and 64 only.
REQ-002 SHALL have parameter REG_OUT, default 1, meaning 1 = registered output with skid buffer and 0 = combinational pass-through with the same ports.
REQ-003 SHALL have port clk, input, width 1, the single rising-edge clock.
REQ-004 SHALL have port rst, input, width 1, the synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, width 1, meaning an upstream instruction is offered.
REQ-006 SHALL have port in_ready, output, width 1, meaning the block accepts the offer this cycle.
REQ-007 SHALL have port instr, input, width 32, the raw instruction word.
REQ-008 SHALL have port ImmSrc, input, type imm_fmt_t, the immediate format select.
REQ-009 SHALL have port out_valid, output, width 1, meaning ImmOp/out_fmt/out_err hold a result.
REQ-010 SHALL have port out_ready, input, width 1, meaning downstream consumes the result.
REQ-011 SHALL have port ImmOp, output, width XLEN, the extended immediate.
REQ-012 SHALL have port out_fmt, output, type imm_fmt_t, the format that produced ImmOp.
REQ-013 SHALL have port out_err, output, width 1, the illegal-format/shamt flag.

Function
REQ-014 Imm SHALL produce sign-extended instr[31:20].
REQ-015 Store SHALL produce sign-extended {instr[31:25],instr[11:7]}.
REQ-016 Branch SHALL produce sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],0}.
REQ-017 Jump SHALL produce sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-018 UpperImm SHALL produce {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-019 CsrImm SHALL produce instr[19:15] zero-extended.
REQ-020 Shamt SHALL produce instr[25:20] zero-extended; when XLEN=32 and instr[25]=1, out_err SHALL be 1 and ImmOp SHALL be instr[24:20].
REQ-021 Any other ImmSrc encoding SHALL be decoded as Imm with out_err=1; out_err SHALL be 0 in all legal cases.
REQ-022 A transfer SHALL occur on a rising edge with valid & ready; no other edge SHALL move data.
REQ-023 With REG_OUT=1, state SHALL be an output slot and one skid slot; latency in_valid→out_valid SHALL be exactly 1 cycle when the output is free.
REQ-024 in_ready SHALL be registered and equal to NOT skid_valid; in_ready SHALL never depend combinationally on out_ready.
REQ-025 On an accept, the result SHALL go to the output slot if that slot is empty or being consumed this cycle and the skid is empty; otherwise it SHALL go to the skid.
REQ-026 When the output slot is consumed and the skid is full, the skid SHALL move to the output slot in the same edge.
REQ-027 Sustained throughput SHALL be 1 result per cycle with out_ready=1; results SHALL leave strictly in acceptance order with none lost or duplicated.
REQ-028 ImmOp, out_fmt and out_err SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 With REG_OUT=0, the outputs SHALL be in_ready=out_ready, out_valid=in_valid, and combinational ImmOp.

Reset
REQ-030 On any edge with rst=1, the output slot and skid SHALL be emptied, giving out_valid=0, ImmOp=0, out_fmt=Imm and out_err=0.
REQ-031 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst falls.
REQ-032 A reset mid-operation SHALL discard both slots; no pre-reset result SHALL appear afterwards.

Structure
REQ-033 types_pkg SHALL gain imm_fmt_t = {Imm, Store, UpperImm, Branch, Jump, CsrImm, Shamt}, encoded in 3 bits, plus the XLEN_MAX=64 constant.
REQ-034 Decode SHALL sit in one combinational sub-module imm_decode (instr, ImmSrc, XLEN → imm, err), instantiated once at the input side.
REQ-035 The skid/output registers SHALL live in imm_extend_pipe.

Verification
REQ-036 Test: XLEN=32 with Imm and instr 0xFFF00093 → ImmOp 0xFFFFFFFF one cycle later; XLEN=64 → 0xFFFFFFFFFFFFFFFF.
REQ-037 Test: Store 0xFE20AE23 → 0xFFFFFFFC; Branch 0xFE000CE3 → 0xFFFFFFF8; Jump 0x001000EF → 0x00000800; UpperImm 0x123450B7 → 0x12345000.
REQ-038 Test: Shamt with instr[25]=1 at XLEN=32 → out_err=1; CsrImm with instr[19:15]=0x1F → ImmOp 0x1F.
REQ-039 Test: 4 back-to-back inputs with out_ready=0 for 3 cycles → in_ready drops after 2 accepts, outputs stay stable, and all 4 emerge in order.
REQ-040 Test: rst pulse with both slots full → out_valid=0 and in_ready=0 next cycle, in_ready=1 after release, and no stale output.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the immediate-extension pipeline: format select encoding
// and the widest supported datapath.
package types_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        Imm      = 3'd0,
        Store    = 3'd1,
        UpperImm = 3'd2,
        Branch   = 3'd3,
        Jump     = 3'd4,
        CsrImm   = 3'd5,
        Shamt    = 3'd6
    } imm_fmt_t;

    // Encoding 3'd7 is the only value outside the defined set.
    function automatic logic fmt_legal(input imm_fmt_t f);
        return f <= Shamt;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational immediate decoder: selects and extends the instruction's
// immediate field for the requested format and flags illegal requests.
module imm_decode
    import types_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_t        ImmSrc,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (ImmSrc)
            Imm:      imm = XLEN'($signed(instr[31:20]));
            Store:    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            Branch:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            Jump:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            UpperImm: imm = XLEN'($signed({instr[31:12], 12'b0}));
            CsrImm:   imm = XLEN'(instr[19:15]);
            Shamt: begin
                // A 6-bit shift amount is meaningless on a 32-bit datapath.
                if (XLEN == 32 && instr[25]) begin
                    imm = XLEN'(instr[24:20]);
                    err = 1'b1;
                end else begin
                    imm = XLEN'(instr[25:20]);
                end
            end
            default: begin
                imm = XLEN'($signed(instr[31:20]));
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension stage with a valid/ready handshake. REG_OUT=1 gives a
// registered output slot backed by a one-entry skid; REG_OUT=0 is a pass-through.
module imm_extend_pipe
    import types_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  imm_fmt_t        ImmSrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ImmOp,
    output imm_fmt_t        out_fmt,
    output logic            out_err
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    imm_fmt_t        dec_fmt;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr  (instr),
        .ImmSrc (ImmSrc),
        .imm    (dec_imm),
        .err    (dec_err)
    );

    // Illegal selects decode as Imm, so report Imm as the producing format.
    assign dec_fmt = fmt_legal(ImmSrc) ? ImmSrc : Imm;

    if (REG_OUT != 0) begin : g_reg
        logic            out_v,   skid_v;
        logic [XLEN-1:0] out_imm, skid_imm;
        imm_fmt_t        out_f,   skid_f;
        logic            out_e,   skid_e;
        logic            accept,  consume;

        // Ready comes only from the skid register, never from out_ready.
        assign in_ready = ~skid_v & ~rst;
        assign accept   = in_valid & in_ready;
        assign consume  = out_v & out_ready;

        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: payload registers are reset too, because ImmOp must read zero out of reset.
                out_v    <= 1'b0;
                out_imm  <= '0;
                out_f    <= Imm;
                out_e    <= 1'b0;
                skid_v   <= 1'b0;
                skid_imm <= '0;
                skid_f   <= Imm;
                skid_e   <= 1'b0;
            end else if (consume && skid_v) begin
                // A full skid blocks accept, so only the refill happens here.
                out_imm <= skid_imm;
                out_f   <= skid_f;
                out_e   <= skid_e;
                skid_v  <= 1'b0;
            end else if (accept && (!out_v || consume)) begin
                out_v   <= 1'b1;
                out_imm <= dec_imm;
                out_f   <= dec_fmt;
                out_e   <= dec_err;
            end else if (accept) begin
                skid_v   <= 1'b1;
                skid_imm <= dec_imm;
                skid_f   <= dec_fmt;
                skid_e   <= dec_err;
            end else if (consume) begin
                out_v <= 1'b0;
            end
        end

        assign out_valid = out_v;
        assign ImmOp     = out_imm;
        assign out_fmt   = out_f;
        assign out_err   = out_e;
    end else begin : g_comb
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign ImmOp     = dec_imm;
        assign out_fmt   = dec_fmt;
        assign out_err   = dec_err;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: decode vectors at XLEN 32/64, the
// combinational variant, skid back-pressure ordering and mid-operation reset.
module tb_imm_extend_pipe;
    import types_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    imm_fmt_t    ImmSrc;
    logic        out_ready;

    logic        rdy32, vld32, err32;
    logic [31:0] imm32;
    imm_fmt_t    fmt32;
    logic        rdy64, vld64, err64;
    logic [63:0] imm64;
    imm_fmt_t    fmt64;
    logic        rdyc, vldc, errc;
    logic [31:0] immc;
    imm_fmt_t    fmtc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .REG_OUT(1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .instr(instr),
        .ImmSrc(ImmSrc), .out_valid(vld32), .out_ready(out_ready), .ImmOp(imm32),
        .out_fmt(fmt32), .out_err(err32)
    );

    imm_extend_pipe #(.XLEN(64), .REG_OUT(1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .instr(instr),
        .ImmSrc(ImmSrc), .out_valid(vld64), .out_ready(out_ready), .ImmOp(imm64),
        .out_fmt(fmt64), .out_err(err64)
    );

    imm_extend_pipe #(.XLEN(32), .REG_OUT(0)) dutc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyc), .instr(instr),
        .ImmSrc(ImmSrc), .out_valid(vldc), .out_ready(out_ready), .ImmOp(immc),
        .out_fmt(fmtc), .out_err(errc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One isolated transaction through all three instances with out_ready held high.
    task automatic send_one(input string tag, input logic [31:0] w, input imm_fmt_t src,
                            input imm_fmt_t efmt, input logic [31:0] e32, input logic ee32,
                            input logic [63:0] e64, input logic ee64);
        @(negedge clk);
        in_valid  = 1'b1;
        instr     = w;
        ImmSrc    = src;
        out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 64'(rdy32), 64'(1));
        check({tag, "_c_imm"}, 64'(immc), 64'(e32));
        check({tag, "_c_err"}, 64'(errc), 64'(ee32));
        check({tag, "_c_fmt"}, 64'(fmtc), 64'(efmt));
        check({tag, "_c_hs"}, 64'({vldc, rdyc}), 64'(2'b11));
        @(posedge clk);
        #1;
        check({tag, "_vld"}, 64'({vld32, vld64}), 64'(2'b11));
        check({tag, "_imm32"}, 64'(imm32), 64'(e32));
        check({tag, "_err32"}, 64'(err32), 64'(ee32));
        check({tag, "_fmt32"}, 64'(fmt32), 64'(efmt));
        check({tag, "_imm64"}, imm64, e64);
        check({tag, "_err64"}, 64'(err64), 64'(ee64));
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drain"}, 64'({vld32, vld64}), 64'(0));
    endtask

    initial begin
        logic [31:0] items [4];
        logic [31:0] held;
        logic        acc, con, stalled;
        int          idx, oidx;

        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        ImmSrc    = Imm;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 64'(vld32), 64'(0));
        check("rst_rdy", 64'(rdy32), 64'(0));
        check("rst_imm", 64'(imm32), 64'(0));
        check("rst_fmt_err", 64'({fmt32, err32}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_rdy", 64'(rdy32), 64'(1));

        // Decode vectors
        send_one("imm",   32'hFFF00093, Imm,      Imm,      32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_one("store", 32'hFE20AE23, Store,    Store,    32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_one("br",    32'hFE000CE3, Branch,   Branch,   32'hFFFFFFF8, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        send_one("jal",   32'h001000EF, Jump,     Jump,     32'h00000800, 1'b0, 64'h0000000000000800, 1'b0);
        send_one("lui",   32'h123450B7, UpperImm, UpperImm, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0);
        send_one("luineg",32'h800000B7, UpperImm, UpperImm, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
        send_one("csr",   32'h000F8073, CsrImm,   CsrImm,   32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
        send_one("sh6",   32'h02100013, Shamt,    Shamt,    32'h00000001, 1'b1, 64'h0000000000000021, 1'b0);
        send_one("sh5",   32'h01F00013, Shamt,    Shamt,    32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
        send_one("illeg", 32'hFFF00093, imm_fmt_t'(3'd7), Imm, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1);

        // Back-pressure: out_ready low for the first three edges, four offers
        items[0] = 32'h00100013;
        items[1] = 32'h00200013;
        items[2] = 32'h00300013;
        items[3] = 32'h00400013;
        idx     = 0;
        oidx    = 0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 20 && oidx < 4; cyc++) begin
            @(negedge clk);
            in_valid  = (idx < 4);
            instr     = (idx < 4) ? items[idx] : 32'h0;
            ImmSrc    = Imm;
            out_ready = (cyc >= 3);
            #1;
            if (stalled) check("bp_hold", 64'(imm32), 64'(held));
            if (cyc == 2) check("bp_rdy_low", 64'({rdy32, idx[2:0]}), 64'({1'b0, 3'd2}));
            acc     = in_valid & rdy32;
            con     = vld32 & out_ready;
            stalled = vld32 & ~out_ready;
            held    = imm32;
            if (con) begin
                check("bp_order", 64'(held), 64'(oidx + 1));
                oidx++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        check("bp_all_out", 64'(oidx), 64'(4));
        check("bp_all_in", 64'(idx), 64'(4));
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_empty", 64'(vld32), 64'(0));

        // Reset with both slots occupied
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00500013;
        @(negedge clk);
        instr     = 32'h00600013;
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
        check("full_rdy", 64'({rdy32, vld32, imm32}), {31'd0, 1'b0, 1'b1, 32'h5});
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_vld", 64'(vld32), 64'(0));
        check("mrst_rdy", 64'(rdy32), 64'(0));
        check("mrst_imm", 64'(imm32), 64'(0));
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mrst_rel_rdy", 64'(rdy32), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mrst_no_stale", 64'({vld32, vld64}), 64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
